// File: rtl/cdb_pkg.sv
// Constants and slot type shared by the CDB arbiter, the reservation stations and the ROB.
package cdb_pkg;

  localparam int ROB_SIZE = 16;
  localparam logic [5:0] invalidNum = 6'b010000;

  typedef struct packed {
    logic        iscast;
    logic [5:0]  robNum;
    logic [31:0] data;
  } cdb_slot_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Round-robin selector: picks the first two set bits of a mask, scanning upward from a
// rotating start pointer, and returns the pointer just past the last pick.
module rr_pick2 #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] first_mask,
  output logic [NUM_REQ-1:0] second_mask,
  output logic               first_valid,
  output logic               second_valid,
  output logic [PW-1:0]      next_ptr
);

  logic [PW-1:0] idx;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    first_mask   = '0;
    second_mask  = '0;
    first_valid  = 1'b0;
    second_valid = 1'b0;
    next_ptr     = rr_ptr;
    idx          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (pending[idx]) begin
        if (!first_valid) begin
          first_valid     = 1'b1;
          first_mask[idx] = 1'b1;
          next_ptr        = PW'((int'(idx) + 1) % NUM_REQ);
        end else if (!second_valid) begin
          second_valid     = 1'b1;
          second_mask[idx] = 1'b1;
          next_ptr         = PW'((int'(idx) + 1) % NUM_REQ);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter: one holding register per result producer, with a
// round-robin scheduler broadcasting up to two pending results per cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ROB_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_robNum,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [ROB_W-1:0] IDLE_TAG = ROB_W'(invalidNum);

  logic [NUM_REQ-1:0] pending, picked, accept;
  logic [NUM_REQ-1:0] first_mask, second_mask;
  logic               first_valid, second_valid;
  logic [PW-1:0]      rr_ptr, next_ptr;
  logic [ROB_W-1:0]   tag_q  [NUM_REQ];
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [ROB_W-1:0]   tag1, tag2;
  logic [DATA_W-1:0]  data1, data2;

  rr_pick2 #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .pending      (pending),
    .rr_ptr       (rr_ptr),
    .first_mask   (first_mask),
    .second_mask  (second_mask),
    .first_valid  (first_valid),
    .second_valid (second_valid),
    .next_ptr     (next_ptr)
  );

  // A register being granted this edge can reload at the same edge.
  assign picked    = first_mask | second_mask;
  assign req_ready = {NUM_REQ{~flush}} & (~pending | picked);

  // Tags at or above ROB_SIZE would alias "no dependency" in the RS, so they are dropped.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      accept[i] = req_valid[i] && req_ready[i] &&
                  (req_robNum[i*ROB_W +: ROB_W] < ROB_W'(ROB_SIZE));
    end
  end

  always_comb begin
    tag1  = IDLE_TAG;
    data1 = '0;
    tag2  = IDLE_TAG;
    data2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (first_mask[i]) begin
        tag1  = tag_q[i];
        data1 = data_q[i];
      end
      if (second_mask[i]) begin
        tag2  = tag_q[i];
        data2 = data_q[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= IDLE_TAG;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= IDLE_TAG;
      CDBdata2   <= '0;
    end else if (flush) begin
      pending    <= '0;
      grant      <= '0;
      CDBiscast  <= 1'b0;
      CDBrobNum  <= IDLE_TAG;
      CDBdata    <= '0;
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= IDLE_TAG;
      CDBdata2   <= '0;
    end else begin
      pending    <= (pending & ~picked) | accept;
      rr_ptr     <= next_ptr;
      grant      <= picked;
      CDBiscast  <= first_valid;
      CDBrobNum  <= tag1;
      CDBdata    <= data1;
      CDBiscast2 <= second_valid;
      CDBrobNum2 <= tag2;
      CDBdata2   <= data2;
    end
  end

  // NOTE: the payload is qualified by pending[], so it needs no reset; keeping it out of
  // the reset block lets it map onto plain flops or a small RAM.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        tag_q[i]  <= req_robNum[i*ROB_W +: ROB_W];
        data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic, all
// compared against a per-producer queue model of the round-robin scheduling rules.
module tb_cdb_arbiter;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [23:0]   req_robNum = '0;
  logic [127:0]  req_data = '0;
  logic [3:0]    req_ready;
  logic          flush = 1'b0;
  logic [3:0]    grant;
  logic          CDBiscast, CDBiscast2;
  logic [5:0]    CDBrobNum, CDBrobNum2;
  logic [31:0]   CDBdata, CDBdata2;

  int checks   = 0;
  int failures = 0;

  // Reference model state: one held result per producer plus the round-robin start point.
  bit          m_pend [4];
  logic [5:0]  m_tag  [4];
  logic [31:0] m_data [4];
  int          m_rr;
  int          p1, p2;
  logic [3:0]  e_ready, e_grant;
  logic        e_v1, e_v2;
  logic [5:0]  e_t1, e_t2;
  logic [31:0] e_d1, e_d2;

  cdb_arbiter #(.NUM_REQ(4), .ROB_W(6), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_robNum (req_robNum),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .flush      (flush),
    .grant      (grant),
    .CDBiscast  (CDBiscast),
    .CDBrobNum  (CDBrobNum),
    .CDBdata    (CDBdata),
    .CDBiscast2 (CDBiscast2),
    .CDBrobNum2 (CDBrobNum2),
    .CDBdata2   (CDBdata2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_rr = 0;
    e_grant = '0;
    e_v1 = 0; e_t1 = 6'd16; e_d1 = '0;
    e_v2 = 0; e_t2 = 6'd16; e_d2 = '0;
  endtask

  task automatic model_pick();
    p1 = -1;
    p2 = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_rr + k) % 4;
      if (m_pend[j]) begin
        if (p1 < 0) p1 = j;
        else if (p2 < 0) p2 = j;
      end
    end
    for (int i = 0; i < 4; i++)
      e_ready[i] = !flush && (!m_pend[i] || i == p1 || i == p2);
  endtask

  task automatic model_edge();
    int last;
    e_grant = '0;
    e_v1 = 0; e_t1 = 6'd16; e_d1 = '0;
    e_v2 = 0; e_t2 = 6'd16; e_d2 = '0;
    if (flush) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
    end else begin
      if (p1 >= 0) begin
        e_grant[p1] = 1'b1; e_v1 = 1; e_t1 = m_tag[p1]; e_d1 = m_data[p1]; m_pend[p1] = 0;
      end
      if (p2 >= 0) begin
        e_grant[p2] = 1'b1; e_v2 = 1; e_t2 = m_tag[p2]; e_d2 = m_data[p2]; m_pend[p2] = 0;
      end
      last = (p2 >= 0) ? p2 : p1;
      if (last >= 0) m_rr = (last + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && e_ready[i] && req_robNum[i*6 +: 6] < 6'd16) begin
          m_pend[i] = 1;
          m_tag[i]  = req_robNum[i*6 +: 6];
          m_data[i] = req_data[i*32 +: 32];
        end
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_grant"},  grant,      e_grant);
    check({pfx, "_cast1"},  CDBiscast,  e_v1);
    check({pfx, "_tag1"},   CDBrobNum,  e_t1);
    check({pfx, "_data1"},  CDBdata,    e_d1);
    check({pfx, "_cast2"},  CDBiscast2, e_v2);
    check({pfx, "_tag2"},   CDBrobNum2, e_t2);
    check({pfx, "_data2"},  CDBdata2,   e_d2);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    model_pick();
    check("ready", req_ready, e_ready);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs("cyc");
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic [5:0] tag, input logic [31:0] data);
    req_valid[i] = 1'b1;
    req_robNum[i*6 +: 6] = tag;
    req_data[i*32 +: 32] = data;
  endtask

  task automatic clear_req();
    req_valid = '0;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs("rst_hold");
    @(negedge clock);
    reset = 1'b0;

    // Single result from producer 2.
    set_req(2, 6'd5, 32'h1234);
    cycle();
    clear_req();
    cycle();
    check("single_cast1", CDBiscast, 1'b1);
    check("single_tag1", CDBrobNum, 6'd5);
    check("single_data1", CDBdata, 32'h1234);
    check("single_cast2", CDBiscast2, 1'b0);
    check("single_grant", grant, 4'b0100);

    // Fairness starting from rr_ptr = 3 with every producer continuously valid.
    for (int i = 0; i < 4; i++) set_req(i, 6'(8 + i), 32'hA000 + i);
    cycle();
    cycle();
    check("fair_grant1", grant, 4'b1001);
    cycle();
    check("fair_grant2", grant, 4'b0110);
    cycle();
    check("fair_grant3", grant, 4'b1001);
    clear_req();
    repeat (3) cycle();

    // Reset asserted in the middle of a cycle while results are being broadcast.
    for (int i = 0; i < 4; i++) set_req(i, 6'(1 + i), 32'hB000 + i);
    cycle();
    clear_req();
    cycle();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) cycle();
    check("post_rst_cast", CDBiscast, 1'b0);

    // Four simultaneous results with rr_ptr = 0.
    for (int i = 0; i < 4; i++) set_req(i, 6'(1 + i), 32'hC000 + i);
    cycle();
    clear_req();
    check("four_ready01_a", req_ready[1:0], 2'b11);
    cycle();
    check("four_tag1_a", CDBrobNum, 6'd1);
    check("four_tag2_a", CDBrobNum2, 6'd2);
    check("four_ready01_b", req_ready[1:0], 2'b11);
    cycle();
    check("four_tag1_b", CDBrobNum, 6'd3);
    check("four_tag2_b", CDBrobNum2, 6'd4);
    check("four_ready01_c", req_ready[1:0], 2'b11);

    // Flush while producers 0 and 1 hold results.
    set_req(0, 6'd10, 32'hD0);
    set_req(1, 6'd11, 32'hD1);
    cycle();
    clear_req();
    flush = 1'b1;
    #1;
    check("flush_ready", req_ready, 4'b0000);
    cycle();
    check("flush_cast1", CDBiscast, 1'b0);
    check("flush_cast2", CDBiscast2, 1'b0);
    check("flush_grant", grant, 4'b0000);
    flush = 1'b0;
    set_req(3, 6'd7, 32'h7777);
    cycle();
    clear_req();
    cycle();
    check("after_flush_cast", CDBiscast, 1'b1);
    check("after_flush_tag", CDBrobNum, 6'd7);

    // Tags at or above 16 are never broadcast.
    set_req(1, 6'd16, 32'hE16);
    cycle();
    set_req(1, 6'd20, 32'hE20);
    cycle();
    check("inval_cast_a", CDBiscast, 1'b0);
    clear_req();
    cycle();
    check("inval_cast_b", CDBiscast, 1'b0);
    check("inval_ready1", req_ready[1], 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req_valid  = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        req_robNum[i*6 +: 6] = 6'($urandom_range(0, 19));
        req_data[i*32 +: 32] = $urandom;
      end
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0;
    clear_req();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
